// File: rtl/brq_fp_wb_ctrl_pkg.sv
`default_nettype none
// brq_fp_wb_ctrl_pkg: shared types for the FP writeback controller.
// Rev 1.0
package brq_fp_wb_ctrl_pkg;

  localparam int FpAddrWidth = 5;
  localparam int FpDataWidth = 32;

  typedef struct packed {
    logic [FpAddrWidth-1:0] rd;
    logic [FpDataWidth-1:0] data;
  } fp_wb_req_t;

  typedef enum logic [1:0] {FpWbNone, FpWbLsu, FpWbFifo, FpWbFpu} fp_wb_src_e;

endpackage
`default_nettype wire

// File: rtl/brq_fp_wb_ctrl_if.sv
`default_nettype none
// brq_fp_wb_ctrl_if: issue/scoreboard, FPU, LSU and register-file write signals.
// Rev 1.0
interface brq_fp_wb_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
);
  logic                   issue_valid_i;
  logic [AddrWidth-1:0]   issue_rd_i;
  logic [3*AddrWidth-1:0] rs_addr_i;
  logic [2:0]             rs_used_i;
  logic [AddrWidth-1:0]   chk_rd_i;
  logic                   chk_rd_used_i;
  logic                   hazard_o;
  logic                   fpu_valid_i;
  logic                   fpu_ready_o;
  logic [AddrWidth-1:0]   fpu_rd_i;
  logic [DataWidth-1:0]   fpu_wdata_i;
  logic                   lsu_valid_i;
  logic [AddrWidth-1:0]   lsu_rd_i;
  logic [DataWidth-1:0]   lsu_wdata_i;
  logic                   rf_we_o;
  logic [AddrWidth-1:0]   rf_waddr_o;
  logic [DataWidth-1:0]   rf_wdata_o;
  logic                   busy_o;

  modport slave (
    input  issue_valid_i, issue_rd_i, rs_addr_i, rs_used_i, chk_rd_i, chk_rd_used_i,
    input  fpu_valid_i, fpu_rd_i, fpu_wdata_i, lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    output hazard_o, fpu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
  );

  modport master (
    output issue_valid_i, issue_rd_i, rs_addr_i, rs_used_i, chk_rd_i, chk_rd_used_i,
    output fpu_valid_i, fpu_rd_i, fpu_wdata_i, lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    input  hazard_o, fpu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/brq_fp_wb_fifo.sv
`default_nettype none
// brq_fp_wb_fifo: synchronous FIFO of FPU writeback requests, wrap-bit pointers.
// Rev 1.0
module brq_fp_wb_fifo
  import brq_fp_wb_ctrl_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  fp_wb_req_t wdata,
  output logic       full,
  output logic       empty,
  output fp_wb_req_t head
);
  localparam int PtrW = $clog2(Depth);

  logic [PtrW:0] wptr;
  logic [PtrW:0] rptr;
  fp_wb_req_t    mem [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[PtrW-1:0]] <= wdata;
  end

  // Equal index with differing wrap bits means every slot is occupied.
  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == {1'b1, {PtrW{1'b0}}});
  assign head  = mem[rptr[PtrW-1:0]];

endmodule
`default_nettype wire

// File: rtl/brq_fp_wb_ctrl.sv
`default_nettype none
// brq_fp_wb_ctrl: merges LSU/FPU results onto one RF write port and scoreboards FP dests.
// Rev 1.0
module brq_fp_wb_ctrl
  import brq_fp_wb_ctrl_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int FifoDepth = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  brq_fp_wb_ctrl_if.slave   bus
);
  localparam int NumRegs = 2 ** AddrWidth;

  logic [NumRegs-1:0]   pending;
  logic [NumRegs-1:0]   pending_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fpu_acc;
  logic                 hazard;
  fp_wb_req_t           fpu_req;
  fp_wb_req_t           fifo_head;
  fp_wb_src_e           src;
  logic [AddrWidth-1:0] win_rd;
  logic [DataWidth-1:0] win_data;

  assign fpu_req         = '{rd: bus.fpu_rd_i, data: bus.fpu_wdata_i};
  assign bus.fpu_ready_o = !fifo_full;
  assign fpu_acc         = bus.fpu_valid_i && !fifo_full;

  always_comb begin
    src      = FpWbNone;
    win_rd   = bus.fpu_rd_i;
    win_data = bus.fpu_wdata_i;
    if (bus.lsu_valid_i) begin
      src      = FpWbLsu;
      win_rd   = bus.lsu_rd_i;
      win_data = bus.lsu_wdata_i;
    end else if (!fifo_empty) begin
      src      = FpWbFifo;
      win_rd   = fifo_head.rd;
      win_data = fifo_head.data;
    end else if (fpu_acc) begin
      src = FpWbFpu;
    end
  end

  // Any accepted FPU result that did not take the port directly queues behind older ones.
  assign fifo_push = fpu_acc && (src != FpWbFpu);
  assign fifo_pop  = (src == FpWbFifo);

  brq_fp_wb_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fpu_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
    end else begin
      bus.rf_we_o <= (src != FpWbNone);
      if (src != FpWbNone) begin
        bus.rf_waddr_o <= win_rd;
        bus.rf_wdata_o <= win_data;
      end
    end
  end

  // Clear is applied first so a same-edge issue to the same register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (bus.rf_we_o)       pending_next[bus.rf_waddr_o] = 1'b0;
    if (bus.issue_valid_i) pending_next[bus.issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pending <= '0;
    else       pending <= pending_next;
  end

  always_comb begin
    hazard = bus.chk_rd_used_i && pending[bus.chk_rd_i];
    for (int i = 0; i < 3; i++) begin
      if (bus.rs_used_i[i] && pending[bus.rs_addr_i[i*AddrWidth +: AddrWidth]]) hazard = 1'b1;
    end
  end

  assign bus.hazard_o = hazard;
  assign bus.busy_o   = (|pending) || !fifo_empty;

  a_no_issue_on_hazard: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.issue_valid_i |-> !bus.hazard_o);

  a_write_was_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.rf_we_o |-> pending[bus.rf_waddr_o]);

endmodule
`default_nettype wire

// File: tb/tb_brq_fp_wb_ctrl.sv
`default_nettype none
// tb_brq_fp_wb_ctrl: directed and randomized checks of brq_fp_wb_ctrl against a queue model.
// Rev 1.0
module tb_brq_fp_wb_ctrl;
  import brq_fp_wb_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brq_fp_wb_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) bus();

  brq_fp_wb_ctrl #(.DataWidth(DW), .AddrWidth(AW), .FifoDepth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending flags, an ordered queue of accepted-but-unwritten FPU results.
  bit          m_pend [32];
  fp_wb_req_t  m_q [$];
  bit          m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_live = 1'b0;
  bit          m_fpu_acc = 1'b0;

  always @(posedge clk) begin
    bit         acc;
    bit         have;
    fp_wb_req_t win;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_q.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_fpu_acc = 1'b0;
      m_live = 1'b1;
    end else begin
      acc  = bus.fpu_valid_i && (m_q.size() < DEPTH);
      have = 1'b0;
      win  = '0;
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (bus.issue_valid_i) m_pend[bus.issue_rd_i] = 1'b1;
      if (acc) m_q.push_back(fp_wb_req_t'{rd: bus.fpu_rd_i, data: bus.fpu_wdata_i});
      if (bus.lsu_valid_i) begin
        win  = fp_wb_req_t'{rd: bus.lsu_rd_i, data: bus.lsu_wdata_i};
        have = 1'b1;
      end else if (m_q.size() > 0) begin
        win  = m_q.pop_front();
        have = 1'b1;
      end
      m_we = have;
      if (have) begin
        m_waddr = win.rd;
        m_wdata = win.data;
      end
      m_fpu_acc = acc;
    end
  end

  logic [4:0] wlog [$];

  always @(negedge clk) begin
    bit exp_haz;
    bit any_pend;
    if (m_live) begin
      exp_haz = bus.chk_rd_used_i && m_pend[bus.chk_rd_i];
      for (int i = 0; i < 3; i++)
        if (bus.rs_used_i[i] && m_pend[bus.rs_addr_i[i*AW +: AW]]) exp_haz = 1'b1;
      any_pend = 1'b0;
      foreach (m_pend[i]) if (m_pend[i]) any_pend = 1'b1;
      check("hazard", bus.hazard_o, exp_haz);
      check("fpu_ready", bus.fpu_ready_o, m_q.size() < DEPTH);
      check("busy", bus.busy_o, any_pend || (m_q.size() > 0));
      check("rf_we", bus.rf_we_o, m_we);
      if (m_we) begin
        check("rf_waddr", bus.rf_waddr_o, m_waddr);
        check("rf_wdata", bus.rf_wdata_o, m_wdata);
      end
      if (bus.rf_we_o === 1'b1) wlog.push_back(bus.rf_waddr_o);
    end
  end

  fp_wb_req_t fpu_q [$];
  logic [4:0] outq [$];

  task automatic present();
    if (fpu_q.size() > 0) begin
      bus.fpu_valid_i = 1'b1;
      bus.fpu_rd_i    = fpu_q[0].rd;
      bus.fpu_wdata_i = fpu_q[0].data;
    end else begin
      bus.fpu_valid_i = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.issue_valid_i = 1'b0;
    bus.lsu_valid_i   = 1'b0;
    if (bus.fpu_valid_i && m_fpu_acc) void'(fpu_q.pop_front());
    present();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic fpu_offer(input logic [4:0] rd, input logic [31:0] data);
    fpu_q.push_back(fp_wb_req_t'{rd: rd, data: data});
    if (!bus.fpu_valid_i) present();
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = rd;
    bus.chk_rd_i      = rd;
    bus.chk_rd_used_i = 1'b1;
    bus.rs_used_i     = 3'b000;
    cyc();
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] data);
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = rd;
    bus.lsu_wdata_i = data;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fpu_q.size() > 0 || m_q.size() > 0 || m_we) && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp4 [7];
    bus.issue_valid_i = 1'b0; bus.issue_rd_i = '0; bus.rs_addr_i = '0; bus.rs_used_i = '0;
    bus.chk_rd_i = '0; bus.chk_rd_used_i = 1'b0;
    bus.fpu_valid_i = 1'b0; bus.fpu_rd_i = '0; bus.fpu_wdata_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_wdata_i = '0;

    // Reset held two cycles
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    settle();
    check("t1_rf_we", bus.rf_we_o, 1'b0);
    check("t1_hazard", bus.hazard_o, 1'b0);
    check("t1_fpu_ready", bus.fpu_ready_o, 1'b1);
    check("t1_busy", bus.busy_o, 1'b0);

    // Lone FPU result with bypass
    issue(5'd3);
    bus.chk_rd_used_i = 1'b0;
    bus.rs_addr_i = {10'd0, 5'd3};
    bus.rs_used_i = 3'b001;
    fpu_offer(5'd3, 32'h3F80_0000);
    settle();
    check("t2_hazard_pending", bus.hazard_o, 1'b1);
    cyc(); settle();
    check("t2_we", bus.rf_we_o, 1'b1);
    check("t2_waddr", bus.rf_waddr_o, 5'd3);
    check("t2_wdata", bus.rf_wdata_o, 32'h3F80_0000);
    cyc(); settle();
    check("t2_hazard_clear", bus.hazard_o, 1'b0);
    bus.rs_used_i = 3'b000;

    // LSU and FPU collide
    issue(5'd5); issue(5'd6);
    bus.chk_rd_used_i = 1'b0;
    wlog.delete();
    lsu(5'd5, 32'hAAAA_5555);
    fpu_offer(5'd6, 32'h4000_0000);
    settle();
    check("t3_ready_a", bus.fpu_ready_o, 1'b1);
    cyc(); settle();
    check("t3_ready_b", bus.fpu_ready_o, 1'b1);
    drain(10);
    check("t3_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t3_first", wlog[0], 5'd5);
      check("t3_second", wlog[1], 5'd6);
    end

    // FIFO fills while LSU holds the port
    issue(5'd10); issue(5'd11); issue(5'd12); issue(5'd13);
    issue(5'd1); issue(5'd2); issue(5'd3);
    bus.chk_rd_used_i = 1'b0;
    wlog.delete();
    lsu(5'd10, 32'h10);
    fpu_offer(5'd1, 32'h1); fpu_offer(5'd2, 32'h2); fpu_offer(5'd3, 32'h3);
    cyc();
    lsu(5'd11, 32'h11);
    cyc();
    lsu(5'd12, 32'h12);
    settle();
    check("t4_ready_full", bus.fpu_ready_o, 1'b0);
    check("t4_offer_rd3", bus.fpu_rd_i, 5'd3);
    cyc();
    lsu(5'd13, 32'h13);
    cyc();
    drain(20);
    exp4 = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
    check("t4_nwrites", wlog.size(), 7);
    if (wlog.size() == 7)
      for (int i = 0; i < 7; i++) check($sformatf("t4_order%0d", i), wlog[i], exp4[i]);

    // Set and clear of the same register on one edge
    issue(5'd7);
    bus.chk_rd_used_i = 1'b0;
    fpu_offer(5'd7, 32'h0000_0007);
    cyc(); settle();
    check("t5_we", bus.rf_we_o, 1'b1);
    check("t5_waddr", bus.rf_waddr_o, 5'd7);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i = 5'd7;
    cyc();
    bus.rs_addr_i = {10'd0, 5'd7};
    bus.rs_used_i = 3'b001;
    settle();
    check("t5_still_pending", bus.hazard_o, 1'b1);
    fpu_offer(5'd7, 32'h0000_0077);
    drain(10);
    settle();
    check("t5_cleared", bus.hazard_o, 1'b0);
    bus.rs_used_i = 3'b000;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] rd;
      bit haz;
      int k;
      if (outq.size() > 0 && $urandom_range(3) == 0) begin
        k = $urandom_range(outq.size() - 1);
        lsu(outq[k], $urandom);
        outq.delete(k);
      end
      if (fpu_q.size() == 0 && outq.size() > 0 && $urandom_range(1) == 0) begin
        k = $urandom_range(outq.size() - 1);
        fpu_offer(outq[k], $urandom);
        outq.delete(k);
      end
      rd = 5'($urandom_range(31));
      bus.rs_addr_i = 15'($urandom);
      bus.rs_used_i = 3'($urandom_range(7));
      bus.chk_rd_i = rd;
      bus.chk_rd_used_i = 1'($urandom_range(1));
      haz = bus.chk_rd_used_i && m_pend[rd];
      for (int i = 0; i < 3; i++)
        if (bus.rs_used_i[i] && m_pend[bus.rs_addr_i[i*AW +: AW]]) haz = 1'b1;
      if (bus.chk_rd_used_i && !haz && $urandom_range(1) == 1) begin
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i = rd;
        outq.push_back(rd);
      end
      cyc();
    end
    bus.rs_used_i = 3'b000;
    bus.chk_rd_used_i = 1'b0;
    for (int n = 0; n < 500 && outq.size() > 0; n++) begin
      if (fpu_q.size() == 0) begin
        fpu_offer(outq[0], $urandom);
        outq.delete(0);
      end
      cyc();
    end
    drain(50);
    settle();
    check("rand_idle_busy", bus.busy_o, 1'b0);

    // WAW hazard, then reset with a loaded FIFO
    issue(5'd9);
    settle();
    check("t6_waw", bus.hazard_o, 1'b1);
    issue(5'd20); issue(5'd21); issue(5'd22); issue(5'd23);
    bus.chk_rd_used_i = 1'b0;
    lsu(5'd22, 32'h22);
    fpu_offer(5'd20, 32'h20); fpu_offer(5'd21, 32'h21);
    cyc();
    lsu(5'd23, 32'h23);
    cyc();
    settle();
    check("t6_fifo_full", bus.fpu_ready_o, 1'b0);
    rst = 1'b1;
    cyc();
    wlog.delete();
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    bus.chk_rd_i = 5'd9;
    bus.chk_rd_used_i = 1'b1;
    settle();
    check("t6_no_writes", wlog.size(), 0);
    check("t6_hazard", bus.hazard_o, 1'b0);
    check("t6_busy", bus.busy_o, 1'b0);
    check("t6_ready", bus.fpu_ready_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
